// File: rtl/prog_delay_line.sv
// Run-time programmable delay line with glitch-free tap switching.
// A tap change waits for matching old/new tap values or a timeout.
module prog_delay_line #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 8,
    parameter int TAP_W       = $clog2(DEPTH + 1),
    parameter int DEFAULT_TAP = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [WIDTH-1:0] iD,
    input  logic [TAP_W-1:0] iTAP,
    input  logic             iTAP_LOAD,
    output logic [WIDTH-1:0] oQ,
    output logic [TAP_W-1:0] oTAP_CUR,
    output logic             oTAP_BUSY,
    output logic             oTAP_CLAMP,
    output logic             oTAP_FORCED,
    output logic             oVALID
);

    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int FILL_W = $clog2(DEPTH + 2);

    localparam logic [TAP_W-1:0]  MAX_TAP   = TAP_W'(DEPTH);
    localparam logic [TAP_W-1:0]  DEF_TAP   = TAP_W'(DEFAULT_TAP);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH + 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state, stateNext;

    logic [WIDTH-1:0]  sr [1:DEPTH];
    logic [TAP_W-1:0]  curTap, curTapNext;
    logic [TAP_W-1:0]  newTap, newTapNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [FILL_W-1:0] fill;
    logic              clampQ, clampNext;
    logic              forcedQ, forcedNext;
    logic [WIDTH-1:0]  qReg, qNext;

    logic [WIDTH-1:0]  curVal;
    logic [WIDTH-1:0]  newVal;
    logic [TAP_W-1:0]  reqTap;
    logic              swap;

    // Tap 0 is the live input; tap k is the k-th history stage.
    always_comb begin
        curVal = iD;
        newVal = iD;
        for (int k = 1; k <= DEPTH; k++) begin
            if (curTap == TAP_W'(k)) curVal = sr[k];
            if (newTap == TAP_W'(k)) newVal = sr[k];
        end
    end

    assign reqTap = (iTAP > MAX_TAP) ? MAX_TAP : iTAP;

    always_comb begin
        stateNext  = state;
        curTapNext = curTap;
        newTapNext = newTap;
        cntNext    = cnt;
        clampNext  = 1'b0;
        forcedNext = 1'b0;
        swap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (iTAP_LOAD) begin
                    clampNext = (iTAP > MAX_TAP);
                    if (reqTap != curTap) begin
                        stateNext  = PENDING;
                        newTapNext = reqTap;
                        cntNext    = '0;
                    end
                end
            end
            PENDING: begin
                if (newVal == curVal) begin
                    swap = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    swap       = 1'b1;
                    forcedNext = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        if (swap) begin
            curTapNext = newTap;
            stateNext  = IDLE;
        end
        // The switching edge already loads oQ from the new tap.
        qNext = swap ? newVal : curVal;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 1; k <= DEPTH; k++) sr[k] <= '0;
        end else begin
            sr[1] <= iD;
            for (int k = 2; k <= DEPTH; k++) sr[k] <= sr[k-1];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            curTap  <= DEF_TAP;
            newTap  <= DEF_TAP;
            cnt     <= '0;
            clampQ  <= 1'b0;
            forcedQ <= 1'b0;
            qReg    <= '0;
            fill    <= '0;
        end else begin
            state   <= stateNext;
            curTap  <= curTapNext;
            newTap  <= newTapNext;
            cnt     <= cntNext;
            clampQ  <= clampNext;
            forcedQ <= forcedNext;
            qReg    <= qNext;
            if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
        end
    end

    assign oQ          = qReg;
    assign oTAP_CUR    = curTap;
    assign oTAP_BUSY   = (state == PENDING);
    assign oTAP_CLAMP  = clampQ;
    assign oTAP_FORCED = forcedQ;
    assign oVALID      = (fill == FILL_FULL);

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line against a history-based model.
// Expected outputs are queued at each edge and checked on the next negedge.
module tb_prog_delay_line;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 8;
    localparam int TAP_W   = 4;
    localparam int DEF     = 8;
    localparam int TIMEOUT = 16;

    logic             iCLK = 1'b0;
    logic             iRST;
    logic [WIDTH-1:0] iD;
    logic [TAP_W-1:0] iTAP;
    logic             iTAP_LOAD;
    logic [WIDTH-1:0] oQ;
    logic [TAP_W-1:0] oTAP_CUR;
    logic             oTAP_BUSY;
    logic             oTAP_CLAMP;
    logic             oTAP_FORCED;
    logic             oVALID;

    prog_delay_line #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .TAP_W      (TAP_W),
        .DEFAULT_TAP(DEF),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iD         (iD),
        .iTAP       (iTAP),
        .iTAP_LOAD  (iTAP_LOAD),
        .oQ         (oQ),
        .oTAP_CUR   (oTAP_CUR),
        .oTAP_BUSY  (oTAP_BUSY),
        .oTAP_CLAMP (oTAP_CLAMP),
        .oTAP_FORCED(oTAP_FORCED),
        .oVALID     (oVALID)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [TAP_W-1:0] tap;
        logic             busy;
        logic             clamp;
        logic             forced;
        logic             valid;
    } exp_t;

    exp_t sbq[$];
    int compared   = 0;
    int mismatched = 0;

    // Model: absolute sample history indexed by edge number.
    logic [WIDTH-1:0] hist[int];
    int edgeNo  = 0;
    int rstEdge = 0;
    bit mInit   = 0;
    bit mPend   = 0;
    int mCur    = DEF;
    int mNew    = DEF;
    int mWait   = 0;
    int mFill   = 0;

    function automatic logic [WIDTH-1:0] tapAt(int t, logic [WIDTH-1:0] dNow);
        if (t == 0) return dNow;
        if (edgeNo - t > rstEdge) return hist[edgeNo - t];
        return '0;
    endfunction

    task automatic modelStep();
        exp_t e;
        int   req;
        e = '0;
        if (iRST) begin
            mInit   = 1;
            rstEdge = edgeNo;
            mPend   = 0;
            mCur    = DEF;
            mFill   = 0;
            e.tap   = TAP_W'(DEF);
        end else if (mInit) begin
            if (mFill < DEPTH + 1) mFill++;
            if (mPend) begin
                if (tapAt(mNew, iD) == tapAt(mCur, iD)) begin
                    mCur  = mNew;
                    mPend = 0;
                end else if (mWait == TIMEOUT - 1) begin
                    mCur     = mNew;
                    mPend    = 0;
                    e.forced = 1'b1;
                end else begin
                    mWait++;
                end
            end else if (iTAP_LOAD) begin
                req     = (int'(iTAP) > DEPTH) ? DEPTH : int'(iTAP);
                e.clamp = (int'(iTAP) > DEPTH);
                if (req != mCur) begin
                    mPend = 1;
                    mNew  = req;
                    mWait = 0;
                end
            end
            e.q     = tapAt(mCur, iD);
            e.tap   = TAP_W'(mCur);
            e.busy  = mPend;
            e.valid = (mFill == DEPTH + 1);
        end
        hist[edgeNo] = iD;
        edgeNo++;
        if (mInit) sbq.push_back(e);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iCLK) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("oQ", 32'(oQ), 32'(e.q));
            check("oTAP_CUR", 32'(oTAP_CUR), 32'(e.tap));
            check("oTAP_BUSY", 32'(oTAP_BUSY), 32'(e.busy));
            check("oTAP_CLAMP", 32'(oTAP_CLAMP), 32'(e.clamp));
            check("oTAP_FORCED", 32'(oTAP_FORCED), 32'(e.forced));
            check("oVALID", 32'(oVALID), 32'(e.valid));
        end
    end

    task automatic cyc(input logic r, input logic [WIDTH-1:0] d,
                       input logic [TAP_W-1:0] t, input logic ld);
        iRST      = r;
        iD        = d;
        iTAP      = t;
        iTAP_LOAD = ld;
        @(posedge iCLK);
        modelStep();
        #1;
    endtask

    logic [WIDTH-1:0] rv;

    task automatic ramp(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, rv, '0, 1'b0);
            rv = rv + WIDTH'(1);
        end
    endtask

    task automatic rampLoad(input logic [TAP_W-1:0] t);
        cyc(1'b0, rv, t, 1'b1);
        rv = rv + WIDTH'(1);
    endtask

    initial begin
        logic             r;
        logic             ld;
        logic [WIDTH-1:0] d;
        logic [TAP_W-1:0] t;
        rv = '0;
        cyc(1'b1, '0, '0, 1'b0);
        cyc(1'b1, '0, '0, 1'b0);
        ramp(14);

        for (int i = 0; i < 12; i++) cyc(1'b0, 4'h1, '0, 1'b0);
        cyc(1'b0, 4'h1, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'h1, '0, 1'b0);

        cyc(1'b1, '0, '0, 1'b0);
        rv = '0;
        ramp(12);
        rampLoad(4'd2);
        ramp(25);

        rampLoad(4'd15);
        ramp(20);
        rampLoad(4'd8);
        ramp(3);
        rampLoad(4'd15);
        ramp(3);

        rampLoad(4'd5);
        rampLoad(4'd1);
        ramp(22);

        rampLoad(4'd4);
        ramp(3);
        cyc(1'b1, rv, '0, 1'b0);
        ramp(6);

        cyc(1'b1, rv, 4'd3, 1'b1);
        ramp(4);

        // Mix of full-range and small-range data so taps often match.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) d = WIDTH'($urandom);
            else d = WIDTH'($urandom_range(0, 1)) | 4'h2;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 7) == 0);
            t  = TAP_W'($urandom_range(0, 15));
            cyc(r, d, t, ld);
        end

        @(negedge iCLK);
        #1;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
